// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg
//   Shared types for the AXI4-Lite to system-bus bridge.
//   resp_t         : AXI response codes used by the bridge (OKAY, SLVERR).
//   bridge_state_t : bridge FSM states.
package axi4lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_ACK = 2'b01,
        WR_RESP  = 2'b10,
        RD_RESP  = 2'b11
    } bridge_state_t;

endpackage

// File: rtl/bridge_timeout.sv
// bridge_timeout
//   Cycle counter that flags an unanswered system-bus access.
//   Only instantiated when AXI4LITE_SYS_BRIDGE_TIMEOUT_EN is defined.
// Ports:
//   clk_i      : clock
//   rstn_i     : asynchronous active-low reset
//   clr_i      : hold the counter at zero
//   en_i       : count one cycle spent waiting for an ack
//   expired_o  : counter has reached LIMIT
module bridge_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [15:0] Limit = 16'(LIMIT);

    logic [15:0] r_cnt;
    logic        w_expired;

    assign w_expired = (r_cnt == Limit);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && !w_expired) begin
            // Saturate so a stalled FSM cannot wrap the counter.
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign expired_o = w_expired;

endmodule

// File: rtl/axi4lite_sys_bridge.sv
// axi4lite_sys_bridge
//   AXI4-Lite slave that turns each AXI transaction into one access on the
//   PL system bus. One transaction outstanding at a time; reads and writes
//   alternate when both are pending (read first after reset).
//   Optional macro AXI4LITE_SYS_BRIDGE_TIMEOUT_EN: complete with SLVERR if
//   the system bus does not ack within TIMEOUT cycles of the strobe.
// Ports:
//   clk_i, rstn_i          : clock, asynchronous active-low reset
//   axi_aw*/axi_w*/axi_b*  : AXI write address, data and response channels
//   axi_ar*/axi_r*         : AXI read address and data channels
//   sys_addr/wdata/sel_o   : system-bus request, stable until completion
//   sys_wen_o / sys_ren_o  : single-cycle access strobes
//   sys_rdata/ack/err_i    : system-bus completion
// All outputs are registered.
module axi4lite_sys_bridge
    import axi4lite_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [AW-1:0]   axi_awaddr_i,
    input  logic            axi_awvalid_i,
    output logic            axi_awready_o,
    input  logic [DW-1:0]   axi_wdata_i,
    input  logic [DW/8-1:0] axi_wstrb_i,
    input  logic            axi_wvalid_i,
    output logic            axi_wready_o,
    output logic [1:0]      axi_bresp_o,
    output logic            axi_bvalid_o,
    input  logic            axi_bready_i,
    input  logic [AW-1:0]   axi_araddr_i,
    input  logic            axi_arvalid_i,
    output logic            axi_arready_o,
    output logic [DW-1:0]   axi_rdata_o,
    output logic [1:0]      axi_rresp_o,
    output logic            axi_rvalid_o,
    input  logic            axi_rready_i,
    output logic [AW-1:0]   sys_addr_o,
    output logic [DW-1:0]   sys_wdata_o,
    output logic [DW/8-1:0] sys_sel_o,
    output logic            sys_wen_o,
    output logic            sys_ren_o,
    input  logic [DW-1:0]   sys_rdata_i,
    input  logic            sys_ack_i,
    input  logic            sys_err_i
);

    bridge_state_t   r_state, w_state_d;
    logic            r_awready, w_awready_d;
    logic            r_arready, w_arready_d;
    logic            r_bvalid, w_bvalid_d;
    logic            r_rvalid, w_rvalid_d;
    resp_t           r_bresp, w_bresp_d;
    resp_t           r_rresp, w_rresp_d;
    logic [DW-1:0]   r_rdata, w_rdata_d;
    logic [AW-1:0]   r_addr, w_addr_d;
    logic [DW-1:0]   r_wdata, w_wdata_d;
    logic [DW/8-1:0] r_sel, w_sel_d;
    logic            r_wen, w_wen_d;
    logic            r_ren, w_ren_d;
    logic            r_is_rd, w_is_rd_d;
    // 1: write wins the next tie. Reset to 0 so the first tie goes to read.
    logic            r_wr_prio, w_wr_prio_d;

    logic            w_wr_elig;
    logic            w_rd_elig;
    logic            w_pick_wr;
    logic            w_expired;

    assign w_wr_elig = axi_awvalid_i && axi_wvalid_i;
    assign w_rd_elig = axi_arvalid_i;
    assign w_pick_wr = w_wr_elig && (!w_rd_elig || r_wr_prio);

`ifdef AXI4LITE_SYS_BRIDGE_TIMEOUT_EN
    // Counter sits at zero outside WAIT_ACK, so it reads 0 in the strobe cycle.
    bridge_timeout #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .clr_i     (r_state != WAIT_ACK),
        .en_i      (r_state == WAIT_ACK),
        .expired_o (w_expired)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT;
    assign w_expired        = 1'b0;
`endif

    always_comb begin
        w_state_d   = r_state;
        w_awready_d = 1'b0;
        w_arready_d = 1'b0;
        w_wen_d     = 1'b0;
        w_ren_d     = 1'b0;
        w_bvalid_d  = r_bvalid;
        w_rvalid_d  = r_rvalid;
        w_bresp_d   = r_bresp;
        w_rresp_d   = r_rresp;
        w_rdata_d   = r_rdata;
        w_addr_d    = r_addr;
        w_wdata_d   = r_wdata;
        w_sel_d     = r_sel;
        w_is_rd_d   = r_is_rd;
        w_wr_prio_d = r_wr_prio;

        unique case (r_state)
            IDLE: begin
                // Ready is registered: it pulses in the strobe cycle, while the
                // master still holds valid, completing the handshake there.
                if (w_pick_wr) begin
                    w_awready_d = 1'b1;
                    w_wen_d     = 1'b1;
                    w_addr_d    = axi_awaddr_i;
                    w_wdata_d   = axi_wdata_i;
                    w_sel_d     = axi_wstrb_i;
                    w_is_rd_d   = 1'b0;
                    w_wr_prio_d = 1'b0;
                    w_state_d   = WAIT_ACK;
                end else if (w_rd_elig) begin
                    w_arready_d = 1'b1;
                    w_ren_d     = 1'b1;
                    w_addr_d    = axi_araddr_i;
                    w_sel_d     = '1;
                    w_is_rd_d   = 1'b1;
                    w_wr_prio_d = 1'b1;
                    w_state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sys_ack_i) begin
                    if (r_is_rd) begin
                        w_rdata_d  = sys_rdata_i;
                        w_rresp_d  = sys_err_i ? SLVERR : OKAY;
                        w_rvalid_d = 1'b1;
                        w_state_d  = RD_RESP;
                    end else begin
                        w_bresp_d  = sys_err_i ? SLVERR : OKAY;
                        w_bvalid_d = 1'b1;
                        w_state_d  = WR_RESP;
                    end
                end else if (w_expired) begin
                    if (r_is_rd) begin
                        w_rdata_d  = '0;
                        w_rresp_d  = SLVERR;
                        w_rvalid_d = 1'b1;
                        w_state_d  = RD_RESP;
                    end else begin
                        w_bresp_d  = SLVERR;
                        w_bvalid_d = 1'b1;
                        w_state_d  = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (axi_bready_i) begin
                    w_bvalid_d = 1'b0;
                    w_state_d  = IDLE;
                end
            end
            RD_RESP: begin
                if (axi_rready_i) begin
                    w_rvalid_d = 1'b0;
                    w_state_d  = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= IDLE;
            r_awready <= 1'b0;
            r_arready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_bresp   <= OKAY;
            r_rresp   <= OKAY;
            r_rdata   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_sel     <= '0;
            r_wen     <= 1'b0;
            r_ren     <= 1'b0;
            r_is_rd   <= 1'b0;
            r_wr_prio <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_awready <= w_awready_d;
            r_arready <= w_arready_d;
            r_bvalid  <= w_bvalid_d;
            r_rvalid  <= w_rvalid_d;
            r_bresp   <= w_bresp_d;
            r_rresp   <= w_rresp_d;
            r_rdata   <= w_rdata_d;
            r_addr    <= w_addr_d;
            r_wdata   <= w_wdata_d;
            r_sel     <= w_sel_d;
            r_wen     <= w_wen_d;
            r_ren     <= w_ren_d;
            r_is_rd   <= w_is_rd_d;
            r_wr_prio <= w_wr_prio_d;
        end
    end

    assign axi_awready_o = r_awready;
    assign axi_wready_o  = r_awready;
    assign axi_arready_o = r_arready;
    assign axi_bvalid_o  = r_bvalid;
    assign axi_bresp_o   = r_bresp;
    assign axi_rvalid_o  = r_rvalid;
    assign axi_rresp_o   = r_rresp;
    assign axi_rdata_o   = r_rdata;
    assign sys_addr_o    = r_addr;
    assign sys_wdata_o   = r_wdata;
    assign sys_sel_o     = r_sel;
    assign sys_wen_o     = r_wen;
    assign sys_ren_o     = r_ren;

endmodule

// File: tb/tb_axi4lite_sys_bridge.sv
// tb_axi4lite_sys_bridge
//   Directed bench for axi4lite_sys_bridge with hand-computed expectations.
//   Inputs change 1 time unit after the rising edge; outputs are read there too.
module tb_axi4lite_sys_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] awaddr, wdata, araddr, rdata, sys_addr, sys_wdata, sys_rdata;
    logic [3:0]  wstrb, sys_sel;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        sys_wen, sys_ren, sys_ack, sys_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi4lite_sys_bridge #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (16)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .axi_awaddr_i  (awaddr),
        .axi_awvalid_i (awvalid),
        .axi_awready_o (awready),
        .axi_wdata_i   (wdata),
        .axi_wstrb_i   (wstrb),
        .axi_wvalid_i  (wvalid),
        .axi_wready_o  (wready),
        .axi_bresp_o   (bresp),
        .axi_bvalid_o  (bvalid),
        .axi_bready_i  (bready),
        .axi_araddr_i  (araddr),
        .axi_arvalid_i (arvalid),
        .axi_arready_o (arready),
        .axi_rdata_o   (rdata),
        .axi_rresp_o   (rresp),
        .axi_rvalid_o  (rvalid),
        .axi_rready_i  (rready),
        .sys_addr_o    (sys_addr),
        .sys_wdata_o   (sys_wdata),
        .sys_sel_o     (sys_sel),
        .sys_wen_o     (sys_wen),
        .sys_ren_o     (sys_ren),
        .sys_rdata_i   (sys_rdata),
        .sys_ack_i     (sys_ack),
        .sys_err_i     (sys_err)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    // One transaction: accept in the first cycle, strobe next, ack ack_dly
    // cycles after the strobe, then hold ready low for rdy_dly response cycles.
    task automatic xact(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int ack_dly, input bit err,
                        input logic [31:0] rd, input int rdy_dly);
        logic [1:0] exp_resp;
        exp_resp = err ? 2'b10 : 2'b00;
        if (is_wr) begin
            awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        end else begin
            araddr = addr; arvalid = 1'b1;
        end
        check_val("ready_in_accept_cycle", {awready, wready, arready}, 3'b000);
        tick();
        if (is_wr) begin
            check_val("aw_w_ready", {awready, wready, arready}, 3'b110);
            check_val("wen_pulse", {sys_wen, sys_ren}, 2'b10);
            check_val("sys_wdata", sys_wdata, data);
            check_val("sys_sel_wr", sys_sel, strb);
        end else begin
            check_val("ar_ready", {awready, wready, arready}, 3'b001);
            check_val("ren_pulse", {sys_wen, sys_ren}, 2'b01);
            check_val("sys_sel_rd", sys_sel, 4'hF);
        end
        check_val("sys_addr", sys_addr, addr);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        for (int c = 0; c < ack_dly; c++) begin
            check_val("valid_before_ack", {bvalid, rvalid}, 2'b00);
            tick();
            check_val("strobe_one_cycle", {sys_wen, sys_ren}, 2'b00);
        end
        sys_ack = 1'b1; sys_err = err; sys_rdata = rd;
        tick();
        sys_ack = 1'b0; sys_err = 1'b0; sys_rdata = 32'hDEAD_BEEF;
        for (int c = 0; c <= rdy_dly; c++) begin
            if (is_wr) begin
                check_val("bvalid_held", {bvalid, rvalid}, 2'b10);
                check_val("bresp", bresp, exp_resp);
                bready = (c == rdy_dly);
            end else begin
                check_val("rvalid_held", {bvalid, rvalid}, 2'b01);
                check_val("rresp", rresp, exp_resp);
                check_val("rdata", rdata, rd);
                rready = (c == rdy_dly);
            end
            tick();
        end
        bready = 1'b0; rready = 1'b0;
        check_val("valid_dropped", {bvalid, rvalid}, 2'b00);
    endtask

    initial begin
        rstn = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        sys_rdata = '0; sys_ack = 1'b0; sys_err = 1'b0;
        tick();
        check_val("rst_ctrl", {awready, wready, arready, bvalid, rvalid, sys_wen, sys_ren}, 7'h0);
        check_val("rst_data", {bresp, rresp, rdata, sys_addr, sys_wdata, sys_sel}, 104'h0);
        rstn = 1'b1;
        tick();

        // Single write, ack 2 cycles after the strobe.
        xact(1'b1, 32'h4000_0010, 32'h1234_5678, 4'hF, 2, 1'b0, 32'h0, 0);
        // Single read with slave error.
        xact(1'b0, 32'h4000_0004, 32'h0, 4'h0, 1, 1'b1, 32'hCAFE_F00D, 0);
        // Byte lanes; ack in the strobe cycle; bready held low 5 cycles.
        xact(1'b1, 32'h4000_0020, 32'hA5A5_5A5A, 4'h3, 0, 1'b0, 32'h0, 5);

        // Simultaneous AW/W and AR after reset: read first, then write.
        do_reset();
        awaddr = 32'h4000_0030; wdata = 32'h0BAD_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h4000_0034; arvalid = 1'b1;
        tick();
        check_val("arb_read_first", {awready, arready, sys_wen, sys_ren}, 4'b0101);
        check_val("arb_rd_addr", sys_addr, 32'h4000_0034);
        arvalid = 1'b0; sys_ack = 1'b1; sys_rdata = 32'h0000_0077;
        tick();
        sys_ack = 1'b0;
        check_val("arb_rvalid", rvalid, 1'b1);
        check_val("arb_rdata", rdata, 32'h0000_0077);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check_val("arb_idle_ready", {awready, arready}, 2'b00);
        tick();
        check_val("arb_write_second", {awready, wready, arready, sys_wen}, 4'b1101);
        check_val("arb_wr_addr", sys_addr, 32'h4000_0030);
        awvalid = 1'b0; wvalid = 1'b0; sys_ack = 1'b1;
        tick();
        sys_ack = 1'b0;
        check_val("arb_bvalid", bvalid, 1'b1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        // Last served was a write, so the next tie goes to read again.
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        check_val("arb_alternate", {awready, arready}, 2'b01);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; sys_ack = 1'b1; sys_rdata = 32'h0;
        tick();
        sys_ack = 1'b0; rready = 1'b1;
        tick();
        rready = 1'b0;

        // AW alone must not be accepted; accept decided in the cycle W arrives.
        awaddr = 32'h4000_0040; wdata = 32'h0000_00AB; wstrb = 4'h1; awvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val("aw_alone_no_accept", {awready, wready, sys_wen}, 3'b000);
        end
        wvalid = 1'b1;
        tick();
        check_val("split_accept", {awready, wready, sys_wen}, 3'b111);
        check_val("split_sel", sys_sel, 4'h1);
        awvalid = 1'b0; wvalid = 1'b0; sys_ack = 1'b1;
        tick();
        sys_ack = 1'b0; bready = 1'b1;
        tick();
        bready = 1'b0;

`ifdef AXI4LITE_SYS_BRIDGE_TIMEOUT_EN
        // No ack: SLVERR response 17 cycles after the strobe; late ack ignored.
        araddr = 32'h4000_0050; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check_val("to_strobe", sys_ren, 1'b1);
        for (int c = 0; c < 16; c++) tick();
        check_val("to_not_yet", rvalid, 1'b0);
        tick();
        check_val("to_rvalid", rvalid, 1'b1);
        check_val("to_rresp", rresp, 2'b10);
        check_val("to_rdata", rdata, 32'h0);
        tick();
        tick();
        sys_ack = 1'b1; sys_rdata = 32'h1111_1111;
        tick();
        sys_ack = 1'b0;
        check_val("late_ack_rresp", rresp, 2'b10);
        check_val("late_ack_rdata", rdata, 32'h0);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check_val("to_done", rvalid, 1'b0);
`else
        // No ack and no timeout: the bridge waits indefinitely.
        begin
            bit seen;
            seen = 1'b0;
            araddr = 32'h4000_0050; arvalid = 1'b1;
            tick();
            arvalid = 1'b0;
            for (int c = 0; c < 1000; c++) begin
                tick();
                if (rvalid || bvalid) seen = 1'b1;
            end
            check_val("no_timeout_resp", seen, 1'b0);
            do_reset();
        end
`endif

        // Reset while waiting for ack drops the access immediately.
        araddr = 32'h4000_0060; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check_val("pre_reset_addr", sys_addr, 32'h4000_0060);
        rstn = 1'b0;
        #1;
        check_val("async_rst_ctrl", {awready, wready, arready, bvalid, rvalid, sys_wen, sys_ren},
                  7'h0);
        check_val("async_rst_data", {bresp, rresp, rdata, sys_addr, sys_wdata, sys_sel}, 104'h0);
        tick();
        rstn = 1'b1;
        tick();
        check_val("post_reset_idle", {bvalid, rvalid}, 2'b00);
        xact(1'b0, 32'h4000_0070, 32'h0, 4'h0, 0, 1'b0, 32'h5555_AAAA, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
